// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: default geometry and clear-FSM state encodings.
package register_bank_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [0:0] state_t;

    localparam state_t IDLE     = 1'b0;
    localparam state_t CLEARING = 1'b1;

endpackage : register_bank_pkg

// File: rtl/register_bank_clear_fsm.sv
// Clear sweep controller: walks a counter over every word address once per accepted clear request.
module register_bank_clear_fsm
    import register_bank_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    output logic          busy_o,
    output logic [AW-1:0] sweep_addr_o,
    output logic          clear_o
);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // A clear request arriving mid-sweep is ignored, so only IDLE looks at clr_i.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEARING;
                    cnt_d   = '0;
                end
            end
            CLEARING: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o       = (state_q == CLEARING);
    assign clear_o      = (state_q == CLEARING);
    assign sweep_addr_o = cnt_q;

endmodule : register_bank_clear_fsm

// File: rtl/register_bank.sv
// Register bank with tri-state combinational read, single write port and a background clear sweep.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    WA,
    input  logic             WE,
    input  logic [AW-1:0]    RA,
    input  logic             OE_n,
    input  logic             CLR,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             REJECT
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    sweepAddr;
    logic             clearStrobe;
    logic             wrAccept;
    logic             reject_q, reject_d;

    register_bank_clear_fsm #(
        .DEPTH (DEPTH)
    ) u_clear_fsm (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .clr_i        (CLR),
        .busy_o       (BUSY),
        .sweep_addr_o (sweepAddr),
        .clear_o      (clearStrobe)
    );

    // A write only lands when the bank is idle and no clear is being requested on the same edge.
    assign wrAccept = WE && !CLR && !BUSY;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clearStrobe) begin
            mem_q[sweepAddr] <= '0;
        end else if (wrAccept) begin
            mem_q[WA] <= D;
        end
    end

    // An idle CLR edge rearms REJECT to whether that same edge dropped a write.
    always_comb begin
        reject_d = reject_q;
        if (BUSY) begin
            if (WE) begin
                reject_d = 1'b1;
            end
        end else if (CLR) begin
            reject_d = WE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reject_q <= 1'b0;
        end else begin
            reject_q <= reject_d;
        end
    end

    assign REJECT = reject_q;
    assign Q      = OE_n ? {WIDTH{1'bz}} : mem_q[RA];

endmodule : register_bank
